// File: rtl/sram_march_bist.sv
// March C- built-in self-test engine for a single-port SRAM.
//
// Owns the SRAM port for the whole test run, walks the six March C- elements
// over DEPTH words, compares the read data and reports the outcome.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      run request, only sampled while idle
//   o_sram_wr    SRAM write enable
//   o_sram_addr  SRAM address
//   o_sram_data  SRAM write data
//   i_sram_rout  SRAM read data, valid RD_LAT cycles after a read is issued
//   o_busy       test in progress (RUN or DRAIN)
//   o_done       single-cycle end-of-run pulse
//   o_pass       last completed run saw no mismatches
//   o_fail_addr  address of the first mismatch of the run
//   o_fail_exp   expected data at the first mismatch
//   o_fail_got   received data at the first mismatch
//   o_err_count  mismatch count, saturating at 255
//
// state | meaning
// IDLE  | waiting for i_start, results held
// RUN   | one SRAM operation per cycle through elements M0..M5
// DRAIN | last RD_LAT reads still in flight (skipped when RD_LAT=0)
// DONE  | o_done pulse, o_pass valid, back to IDLE next cycle
module sram_march_bist #(
  parameter int AW     = 5,
  parameter int DW     = 6,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_sram_wr,
  output logic [AW-1:0] o_sram_addr,
  output logic [DW-1:0] o_sram_data,
  input  logic [DW-1:0] i_sram_rout,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [AW-1:0] o_fail_addr,
  output logic [DW-1:0] o_fail_exp,
  output logic [DW-1:0] o_fail_got,
  output logic [7:0]    o_err_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [AW-1:0] LAST       = AW'(DEPTH - 1);
  localparam logic [1:0]    DRAIN_LOAD = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  localparam logic [DW-1:0] B0         = '0;
  localparam logic [DW-1:0] B1         = '1;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_elem;
  logic [AW-1:0] r_cnt;
  logic          r_wph;
  logic [1:0]    r_drain;
  logic [7:0]    r_err;
  logic          r_pass;
  logic          r_first;
  logic [AW-1:0] r_fail_addr;
  logic [DW-1:0] r_fail_exp;
  logic [DW-1:0] r_fail_got;

  logic          w_two_op;
  logic          w_desc;
  logic          w_is_wr;
  logic          w_rd;
  logic          w_last_op;
  logic          w_accept;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wr_bg;
  logic [DW-1:0] w_rd_exp;

  // r_cnt counts down the words left in the element; ascending elements
  // map it to LAST-r_cnt so both directions share one terminal count.
  // r_wph selects the write half of a read-then-write element.
  always_comb begin
    w_two_op  = (r_elem >= 3'd1) && (r_elem <= 3'd4);
    w_desc    = (r_elem == 3'd3) || (r_elem == 3'd4);
    w_is_wr   = (r_elem == 3'd0) || (w_two_op && r_wph);
    w_addr    = w_desc ? r_cnt : LAST - r_cnt;
    w_wr_bg   = ((r_elem == 3'd1) || (r_elem == 3'd3)) ? B1 : B0;
    w_rd_exp  = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? B1 : B0;
    w_last_op = (r_elem == 3'd5) && (r_cnt == '0);
  end

  assign w_rd     = (r_state == S_RUN) && !w_is_wr;
  assign w_accept = (r_state == S_IDLE) && i_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_sram_wr   = 1'b0;
    o_sram_addr = '0;
    o_sram_data = '0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_busy      = 1'b1;
        o_sram_wr   = w_is_wr;
        o_sram_addr = w_addr;
        o_sram_data = w_is_wr ? w_wr_bg : '0;
        if (w_last_op) w_state_nxt = (RD_LAT == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (r_drain == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_elem  <= '0;
      r_cnt   <= '0;
      r_wph   <= 1'b0;
      r_drain <= '0;
    end else if (w_accept) begin
      r_elem <= '0;
      r_cnt  <= LAST;
      r_wph  <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_last_op) r_drain <= DRAIN_LOAD;
      if (w_two_op && !r_wph) begin
        r_wph <= 1'b1;
      end else begin
        r_wph <= 1'b0;
        if (r_cnt == '0) begin
          r_elem <= r_elem + 3'd1;
          r_cnt  <= LAST;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end else if (r_state == S_DRAIN) begin
      r_drain <= r_drain - 2'd1;
    end
  end

  // Compare pipeline: each read carries its address and expected word until
  // the SRAM data for it arrives.
  logic          w_cmp_vld;
  logic [AW-1:0] w_cmp_addr;
  logic [DW-1:0] w_cmp_exp;

  generate
    if (RD_LAT == 0) begin : g_nolat
      assign w_cmp_vld  = w_rd;
      assign w_cmp_addr = w_addr;
      assign w_cmp_exp  = w_rd_exp;
    end else begin : g_pipe
      logic [RD_LAT-1:0]         r_pv;
      logic [RD_LAT-1:0][AW-1:0] r_pa;
      logic [RD_LAT-1:0][DW-1:0] r_pe;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_pv <= '0;
          r_pa <= '0;
          r_pe <= '0;
        end else begin
          r_pv[0] <= w_rd;
          r_pa[0] <= w_addr;
          r_pe[0] <= w_rd_exp;
          for (int i = 1; i < RD_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pa[i] <= r_pa[i-1];
            r_pe[i] <= r_pe[i-1];
          end
        end
      end

      assign w_cmp_vld  = r_pv[RD_LAT-1];
      assign w_cmp_addr = r_pa[RD_LAT-1];
      assign w_cmp_exp  = r_pe[RD_LAT-1];
    end
  endgenerate

  logic       w_mis;
  logic [7:0] w_err_nxt;

  assign w_mis     = w_cmp_vld && (i_sram_rout != w_cmp_exp);
  assign w_err_nxt = (w_mis && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err       <= '0;
      r_pass      <= 1'b0;
      r_first     <= 1'b0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
    end else if (w_accept) begin
      r_err       <= '0;
      r_pass      <= 1'b0;
      r_first     <= 1'b0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
    end else begin
      r_err <= w_err_nxt;
      if (w_mis && !r_first) begin
        r_first     <= 1'b1;
        r_fail_addr <= w_cmp_addr;
        r_fail_exp  <= w_cmp_exp;
        r_fail_got  <= i_sram_rout;
      end
      // Uses the post-compare count so the final read is included even with
      // RD_LAT=0, where it lands in the same cycle RUN hands over to DONE.
      if (w_state_nxt == S_DONE) r_pass <= (w_err_nxt == 8'd0);
    end
  end

  assign o_pass      = r_pass;
  assign o_err_count = r_err;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_exp  = r_fail_exp;
  assign o_fail_got  = r_fail_got;

endmodule
